// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and main-memory signals of the shared memory port arbiter
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            req_i;
  logic [1:0]            we_i;
  logic [DATA_WIDTH-1:0] addr0_i;
  logic [DATA_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wd0_i;
  logic [DATA_WIDTH-1:0] wd1_i;
  logic [1:0]            ack_o;
  logic [DATA_WIDTH-1:0] rd_o;
  logic                  stall_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wd_o;
  logic                  mem_we_o;
  logic                  mem_re_o;
  logic [DATA_WIDTH-1:0] mem_rd_i;

  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wd0_i, wd1_i, mem_rd_i,
    output ack_o, rd_o, stall_o, mem_addr_o, mem_wd_o, mem_we_o, mem_re_o
  );

  modport master (
    output req_i, we_i, addr0_i, addr1_i, wd0_i, wd1_i, mem_rd_i,
    input  ack_o, rd_o, stall_o, mem_addr_o, mem_wd_o, mem_we_o, mem_re_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one main-memory port between I-side and D-side caches
// Optional performance counters enabled by MEM_PORT_ARBITER_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_port_arbiter_if.slave        bus
`ifdef MEM_PORT_ARBITER_PERF_CNT_EN
  ,
  output logic [31:0]              conflict_cnt_o,
  output logic [31:0]              wait_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  state_t                state_q;
  logic                  last_grant_q;
  logic                  id_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [3:0]            cnt_q;

  logic                  grant_d;
  logic                  read_done;
  logic                  done;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.addr0_i[1:0], bus.addr1_i[1:0]};

  // With both requesting, the one not served last wins; a lone request wins outright.
  assign grant_d = (bus.req_i == 2'b11) ? ~last_grant_q : bus.req_i[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req_i) begin
            id_q         <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= bus.we_i[grant_d];
            addr_q       <= grant_d ? {bus.addr1_i[DATA_WIDTH-1:2], 2'b00}
                                    : {bus.addr0_i[DATA_WIDTH-1:2], 2'b00};
            wd_q         <= grant_d ? bus.wd1_i : bus.wd0_i;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= CNT_LOAD;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state so reset clears strobes and ack without waiting for a clock.
  assign read_done      = (state_q == WAIT) && (cnt_q == 4'd0);
  assign done           = read_done || ((state_q == ACCESS) && we_q);
  assign bus.ack_o      = done ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rd_o       = read_done ? bus.mem_rd_i : '0;
  assign bus.mem_we_o   = (state_q == ACCESS) && we_q;
  assign bus.mem_re_o   = (state_q == ACCESS) && !we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_wd_o   = wd_q;
  assign bus.stall_o    = |(bus.req_i & ~bus.ack_o);

`ifdef MEM_PORT_ARBITER_PERF_CNT_EN
  logic [31:0] conflict_cnt_q;
  logic [31:0] wait_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt_q <= '0;
      wait_cnt_q     <= '0;
    end else begin
      if ((state_q == IDLE) && (bus.req_i == 2'b11) && (conflict_cnt_q != 32'hFFFF_FFFF))
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      if (bus.stall_o && (wait_cnt_q != 32'hFFFF_FFFF))
        wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign wait_cnt_o     = wait_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (READ_LATENCY = 2)
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  mem_port_arbiter_if #(.DATA_WIDTH(32)) bus ();

`ifdef MEM_PORT_ARBITER_PERF_CNT_EN
  logic [31:0] conflict_cnt;
  logic [31:0] wait_cnt;
`endif

  mem_port_arbiter #(
    .DATA_WIDTH   (32),
    .READ_LATENCY (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus)
`ifdef MEM_PORT_ARBITER_PERF_CNT_EN
    ,
    .conflict_cnt_o (conflict_cnt),
    .wait_cnt_o     (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset       = 1'b1;
    bus.req_i   = 2'b00;
    bus.we_i    = 2'b00;
    bus.addr0_i = '0;
    bus.addr1_i = '0;
    bus.wd0_i   = '0;
    bus.wd1_i   = '0;
    bus.mem_rd_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.req_i = 2'b01;
    @(negedge clk);
    n_total++;
    if (bus.ack_o !== 2'b00) $display("FAIL reset_ack got %b want 00", bus.ack_o); else n_pass++;
    n_total++;
    if ({bus.mem_we_o, bus.mem_re_o} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {bus.mem_we_o, bus.mem_re_o}); else n_pass++;
    n_total++;
    if ({bus.mem_addr_o, bus.mem_wd_o} !== 64'h0) $display("FAIL reset_addr_wd got %h want 0", {bus.mem_addr_o, bus.mem_wd_o}); else n_pass++;
    n_total++;
    if (bus.stall_o !== 1'b1) $display("FAIL reset_stall_req got %b want 1", bus.stall_o); else n_pass++;
    bus.req_i = 2'b00;
    #1;
    n_total++;
    if (bus.stall_o !== 1'b0) $display("FAIL reset_stall_idle got %b want 0", bus.stall_o); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_read();
    logic [1:0] exp_ack   [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic       exp_re    [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_stall [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    bus.req_i    = 2'b01;
    bus.we_i     = 2'b00;
    bus.addr0_i  = 32'h104;
    bus.mem_rd_i = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_total++;
      if (bus.ack_o !== exp_ack[k]) $display("FAIL read_ack cyc%0d got %b want %b", k, bus.ack_o, exp_ack[k]); else n_pass++;
      n_total++;
      if (bus.mem_re_o !== exp_re[k]) $display("FAIL read_re cyc%0d got %b want %b", k, bus.mem_re_o, exp_re[k]); else n_pass++;
      n_total++;
      if (bus.stall_o !== exp_stall[k]) $display("FAIL read_stall cyc%0d got %b want %b", k, bus.stall_o, exp_stall[k]); else n_pass++;
      if (k == 1) begin
        n_total++;
        if (bus.mem_addr_o !== 32'h104) $display("FAIL read_addr got %h want 00000104", bus.mem_addr_o); else n_pass++;
      end
      if (k == 3) begin
        n_total++;
        if (bus.rd_o !== 32'hDEADBEEF) $display("FAIL read_data got %h want deadbeef", bus.rd_o); else n_pass++;
      end
      @(posedge clk); #1;
      if (k == 3) bus.req_i = 2'b00;
    end
  endtask

  task automatic test_write();
    do_reset();
    bus.req_i   = 2'b10;
    bus.we_i    = 2'b10;
    bus.addr1_i = 32'h20003;
    bus.wd1_i   = 32'h12345678;
    @(negedge clk);
    n_total++;
    if (bus.mem_we_o !== 1'b0) $display("FAIL write_we_idle got %b want 0", bus.mem_we_o); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({bus.mem_we_o, bus.mem_re_o} !== 2'b10) $display("FAIL write_strobes got %b want 10", {bus.mem_we_o, bus.mem_re_o}); else n_pass++;
    n_total++;
    if (bus.mem_addr_o !== 32'h20000) $display("FAIL write_addr got %h want 00020000", bus.mem_addr_o); else n_pass++;
    n_total++;
    if (bus.mem_wd_o !== 32'h12345678) $display("FAIL write_data got %h want 12345678", bus.mem_wd_o); else n_pass++;
    n_total++;
    if (bus.ack_o !== 2'b10) $display("FAIL write_ack got %b want 10", bus.ack_o); else n_pass++;
    n_total++;
    if (bus.stall_o !== 1'b0) $display("FAIL write_stall got %b want 0", bus.stall_o); else n_pass++;
    @(posedge clk); #1;
    bus.req_i = 2'b00;
    @(negedge clk);
    n_total++;
    if ({bus.ack_o, bus.mem_we_o} !== 3'b000) $display("FAIL write_after got %b want 000", {bus.ack_o, bus.mem_we_o}); else n_pass++;
  endtask

  task automatic test_alternation();
    logic [1:0]  exp_ack;
    logic [31:0] exp_addr;
    do_reset();
    bus.req_i    = 2'b11;
    bus.we_i     = 2'b00;
    bus.addr0_i  = 32'h100;
    bus.addr1_i  = 32'h200;
    bus.mem_rd_i = 32'hA5A5_0001;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_ack = (k % 4 == 3) ? (((k / 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_total++;
      if (bus.ack_o !== exp_ack) $display("FAIL alt_ack cyc%0d got %b want %b", k, bus.ack_o, exp_ack); else n_pass++;
      n_total++;
      if (bus.stall_o !== 1'b1) $display("FAIL alt_stall cyc%0d got %b want 1", k, bus.stall_o); else n_pass++;
      if (k % 4 == 1) begin
        exp_addr = ((k / 4) % 2 == 1) ? 32'h200 : 32'h100;
        n_total++;
        if (bus.mem_addr_o !== exp_addr) $display("FAIL alt_addr cyc%0d got %h want %h", k, bus.mem_addr_o, exp_addr); else n_pass++;
      end
`ifdef MEM_PORT_ARBITER_PERF_CNT_EN
      if (k == 15) begin
        n_total++;
        if (conflict_cnt !== 32'd4) $display("FAIL alt_conflict_cnt got %0d want 4", conflict_cnt); else n_pass++;
        n_total++;
        if (wait_cnt !== 32'd15) $display("FAIL alt_wait_cnt got %0d want 15", wait_cnt); else n_pass++;
      end
`endif
      @(posedge clk); #1;
    end
    bus.req_i = 2'b00;
  endtask

  task automatic test_drop_after_grant();
    logic [1:0] exp_ack [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    int         acks;
    acks = 0;
    do_reset();
    bus.req_i   = 2'b10;
    bus.we_i    = 2'b00;
    bus.addr1_i = 32'h300;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_total++;
      if (bus.ack_o !== exp_ack[k]) $display("FAIL drop_ack cyc%0d got %b want %b", k, bus.ack_o, exp_ack[k]); else n_pass++;
      if (bus.ack_o != 2'b00) acks++;
      @(posedge clk); #1;
      bus.req_i = 2'b00;
    end
    n_total++;
    if (acks !== 1) $display("FAIL drop_ack_count got %0d want 1", acks); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    bus.req_i    = 2'b01;
    bus.we_i     = 2'b00;
    bus.addr0_i  = 32'h104;
    bus.addr1_i  = 32'h204;
    bus.mem_rd_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if ({bus.ack_o, bus.mem_we_o, bus.mem_re_o} !== 4'b0000) $display("FAIL rstwait_ctrl got %b want 0000", {bus.ack_o, bus.mem_we_o, bus.mem_re_o}); else n_pass++;
    n_total++;
    if ({bus.mem_addr_o, bus.mem_wd_o, bus.rd_o} !== 96'h0) $display("FAIL rstwait_data got %h want 0", {bus.mem_addr_o, bus.mem_wd_o, bus.rd_o}); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (bus.ack_o !== 2'b00) $display("FAIL rstwait_noack got %b want 00", bus.ack_o); else n_pass++;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.req_i = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (bus.mem_addr_o !== 32'h104) $display("FAIL rstwait_first_grant got %h want 00000104", bus.mem_addr_o); else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (bus.ack_o !== 2'b01) $display("FAIL rstwait_first_ack got %b want 01", bus.ack_o); else n_pass++;
    @(posedge clk); #1;
    bus.req_i = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic       exp_re  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] exp_ack [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    do_reset();
    bus.req_i    = 2'b01;
    bus.we_i     = 2'b00;
    bus.addr0_i  = 32'h104;
    bus.mem_rd_i = 32'h0BAD_F00D;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_total++;
      if (bus.mem_re_o !== exp_re[k]) $display("FAIL b2b_re cyc%0d got %b want %b", k, bus.mem_re_o, exp_re[k]); else n_pass++;
      n_total++;
      if (bus.ack_o !== exp_ack[k]) $display("FAIL b2b_ack cyc%0d got %b want %b", k, bus.ack_o, exp_ack[k]); else n_pass++;
      if (k == 5) begin
        n_total++;
        if (bus.mem_addr_o !== 32'h108) $display("FAIL b2b_addr got %h want 00000108", bus.mem_addr_o); else n_pass++;
      end
      @(posedge clk); #1;
      if (k == 3) bus.addr0_i = 32'h108;
    end
    bus.req_i = 2'b00;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    do_reset();
    test_reset();
    test_read();
    test_write();
    test_alternation();
    test_drop_after_grant();
    test_reset_in_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
